// File: rtl/btn_pkg.sv
// Shared constants for the push-button debounce block: FSM state encoding
// and default timing for a 100 MHz CLK.
package btn_pkg;

    // Debounce FSM state encoding
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // 10 ms debounce window and 1 s long-press hold at 100 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES     = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit pin. RESET_VAL sets
// the level both flops hold in reset so that a downstream edge detector sees
// no spurious transition when reset is released.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic pin,
    output logic level
);

    logic meta;

    // Two-stage capture of the asynchronous pin into the CLK domain
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta  <= RESET_VAL;
            level <= RESET_VAL;
        end else begin
            meta  <= pin;
            level <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronises a bouncing pin, qualifies each level
// change over DEBOUNCE_CYCLES consecutive cycles and emits a registered
// debounced level plus one-cycle PRESS / RELEASE pulses.
// Optional feature macro: BTN_LONG_PRESS_EN adds the LONG_PRESS output, a
// one-cycle pulse once the accepted press has been held for LONG_CYCLES.
module button_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic BTN_LEVEL,
    output logic PRESS,
    output logic RELEASE
`ifdef BTN_LONG_PRESS_EN
    ,
    output logic LONG_PRESS
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("button_debounce: need DEBOUNCE_CYCLES >= 1 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic             btn_sync;
    logic             p;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Synchroniser rests at the released pin level so reset never looks like a press
    sync_2ff #(
        .RESET_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .pin   (BTN),
        .level (btn_sync)
    );

    // Pressed-sense of the synchronised pin, independent of board polarity
    assign p        = btn_sync ^ BTN_ACTIVE_LOW;
    assign cnt_done = (cnt == CNT_LAST);

    // State register and debounce counter; the counter restarts on every transition
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state == PRESS_WAIT || state == RELEASE_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Next state: a wait state falls back as soon as p disagrees with its candidate level
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (p) state_nxt = PRESS_WAIT;
            PRESS_WAIT:   if (!p) state_nxt = IDLE;
                          else if (cnt_done) state_nxt = PRESSED;
            PRESSED:      if (!p) state_nxt = RELEASE_WAIT;
            RELEASE_WAIT: if (p) state_nxt = PRESSED;
                          else if (cnt_done) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // Output decode: events only on qualified transitions, never on bounce returns
    always_comb begin
        level_nxt   = BTN_LEVEL;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (state == PRESS_WAIT && state_nxt == PRESSED) begin
            level_nxt = 1'b1;
            press_nxt = 1'b1;
        end
        if (state == RELEASE_WAIT && state_nxt == IDLE) begin
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
        end
    end

    // Registered outputs so nothing downstream sees a combinational path from BTN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BTN_LEVEL <= 1'b0;
            PRESS     <= 1'b0;
            RELEASE   <= 1'b0;
        end else begin
            BTN_LEVEL <= level_nxt;
            PRESS     <= press_nxt;
            RELEASE   <= release_nxt;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold;
    logic              long_nxt;

    // Hold counter: restarts only on a fresh accepted press, survives release bounces
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold <= '0;
        end else if (state == PRESS_WAIT && state_nxt == PRESSED) begin
            hold <= '0;
        end else if (state == PRESSED || state == RELEASE_WAIT) begin
            if (hold != HOLD_MAX) hold <= hold + HOLD_W'(1);
        end else begin
            hold <= '0;
        end
    end

    // Saturation at HOLD_MAX guarantees the match happens once per press
    always_comb begin
        long_nxt = (state == PRESSED || state == RELEASE_WAIT) && (hold == HOLD_LAST);
    end

    // Registered long-press pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) LONG_PRESS <= 1'b0;
        else        LONG_PRESS <= long_nxt;
    end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low pin.
// Long-press checks are built when BTN_LONG_PRESS_EN is defined.
module tb_button_debounce;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam int LAT = 2 + D;

    logic CLK = 1'b0;
    logic RST_N;
    logic BTN;
    logic BTN_LEVEL;
    logic PRESS;
    logic RELEASE;
`ifdef BTN_LONG_PRESS_EN
    logic LONG_PRESS;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .BTN       (BTN),
        .BTN_LEVEL (BTN_LEVEL),
        .PRESS     (PRESS),
`ifdef BTN_LONG_PRESS_EN
        .RELEASE   (RELEASE),
        .LONG_PRESS(LONG_PRESS)
`else
        .RELEASE   (RELEASE)
`endif
    );

    typedef struct {
        logic btn;
        logic lvl;
        logic pr;
        logic rl;
    } vec_t;

    vec_t vecs[$];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic b, input logic l, input logic p, input logic r);
        vec_t v;
        v.btn = b; v.lvl = l; v.pr = p; v.rl = r;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic b, input logic l);
        for (int i = 0; i < n; i++) add(b, l, 1'b0, 1'b0);
    endtask

    task automatic check_all_low(input string tag);
        check_bit({tag, "_level"},   BTN_LEVEL, 1'b0);
        check_bit({tag, "_press"},   PRESS,     1'b0);
        check_bit({tag, "_release"}, RELEASE,   1'b0);
`ifdef BTN_LONG_PRESS_EN
        check_bit({tag, "_long"},    LONG_PRESS, 1'b0);
`endif
    endtask

    // Release reset at a negedge with BTN held pressed; expect one PRESS at sample LAT
    task automatic release_reset_expect_press(input string tag);
        int first;
        int npulse;
        first  = -1;
        npulse = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (PRESS === 1'b1) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        check_int({tag, "_press_cycle"}, first, LAT);
        check_int({tag, "_press_count"}, npulse, 1);
        check_bit({tag, "_level_after"}, BTN_LEVEL, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        BTN   = 1'b1;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;

        // Reset with the button released
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            check_all_low($sformatf("reset%0d", i));
        end
        @(negedge CLK);
        RST_N = 1'b1;

        // Idle, then clean press
        add_n(3, 1'b1, 1'b0);
        add_n(6, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0);
        add_n(2, 1'b0, 1'b1);
        // Clean release
        add_n(6, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b1);
        add_n(2, 1'b1, 1'b0);
        // Press bounce: 8 alternating cycles, then settle
        for (int i = 0; i < 8; i++) add(logic'(i % 2), 1'b0, 1'b0, 1'b0);
        add_n(6, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0);
        add_n(2, 1'b0, 1'b1);
        // Release bounce of 3 cycles returns to pressed silently
        add_n(3, 1'b1, 1'b1);
        add_n(6, 1'b0, 1'b1);
        // Clean release afterwards
        add_n(6, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b1);
        add_n(2, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            BTN = vecs[i].btn;
            @(posedge CLK);
            #1;
            check_bit($sformatf("row%0d_level", i),   BTN_LEVEL, vecs[i].lvl);
            check_bit($sformatf("row%0d_press", i),   PRESS,     vecs[i].pr);
            check_bit($sformatf("row%0d_release", i), RELEASE,   vecs[i].rl);
        end

        // Reset mid PRESS_WAIT with the button held
        @(negedge CLK);
        BTN = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1 check_all_low("rst_pw");
        repeat (2) @(posedge CLK);
        release_reset_expect_press("rst_pw");

        // Reset mid PRESSED: level must drop without waiting for a clock edge
        #2 RST_N = 1'b0;
        #1 check_all_low("rst_pressed");
        repeat (2) @(posedge CLK);
        release_reset_expect_press("rst_pressed");

        // Let go and settle back to idle
        @(negedge CLK);
        BTN = 1'b1;
        repeat (10) @(posedge CLK);
        #1 check_all_low("settle_idle");

`ifdef BTN_LONG_PRESS_EN
        begin
            int p_idx;
            int l_idx;
            int n_long;
            int n_press;
            // Long hold of 40 cycles
            p_idx = -1; l_idx = -1; n_long = 0;
            @(negedge CLK);
            BTN = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge CLK);
                #1;
                if (PRESS === 1'b1 && p_idx < 0) p_idx = i;
                if (LONG_PRESS === 1'b1) begin
                    n_long++;
                    if (l_idx < 0) l_idx = i;
                end
            end
            @(negedge CLK);
            BTN = 1'b1;
            for (int i = 0; i < 15; i++) begin
                @(posedge CLK);
                #1;
                if (LONG_PRESS === 1'b1) n_long++;
            end
            check_int("long_press_cycle", p_idx, LAT);
            check_int("long_fire_cycle", l_idx, LAT + L);
            check_int("long_count", n_long, 1);

            // Short hold of 15 cycles: press but no long press
            n_long = 0; n_press = 0;
            @(negedge CLK);
            BTN = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(posedge CLK);
                #1;
                if (PRESS === 1'b1) n_press++;
                if (LONG_PRESS === 1'b1) n_long++;
            end
            @(negedge CLK);
            BTN = 1'b1;
            for (int i = 0; i < 15; i++) begin
                @(posedge CLK);
                #1;
                if (LONG_PRESS === 1'b1) n_long++;
            end
            check_int("short_press_count", n_press, 1);
            check_int("short_long_count", n_long, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Reads a raw, bouncing push-button pin and converts it into clean control events for the design. It is the input-side counterpart of the LED driver blocks.
- Synchronises the asynchronous pin into the CLK domain, then debounces it with a counter-qualified state machine.
- Emits a debounced level plus single-cycle press, release and (optionally) long-press pulses for downstream logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive CLK cycles the input must hold a new level before the change is accepted (10 ms at 100 MHz); must be >= 1.
- LONG_CYCLES, 100000000, CLK cycles of accepted press before LONG_PRESS fires (1 s at 100 MHz); must be > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- CLK  input  1  system clock, 100 MHz nominal
- RST_N  input  1  asynchronous active-low reset
- BTN  input  1  raw button pin, asynchronous to CLK, bouncing
- BTN_LEVEL  output  1  debounced level, 1 = pressed
- PRESS  output  1  one-cycle pulse on accepted press
- RELEASE  output  1  one-cycle pulse on accepted release
- LONG_PRESS  output  1  one-cycle pulse after a sustained hold (present only with macro; see Optional Feature)

Behaviour:
- Interface (decided): one clock, CLK. Reset RST_N is asynchronous and active-low. All flops clear on the RST_N falling edge, and reset release is synchronous to CLK.
- Reset values:
  - BTN_LEVEL=0, PRESS=0, RELEASE=0, LONG_PRESS=0.
  - State=IDLE; both counters 0.
  - Synchroniser flops hold the "not pressed" pin level, so reset never produces a spurious event.
- Synchroniser: two flops on BTN, then polarity normalisation. p = pressed-sense of the second flop.
- Debounce counter:
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - Clears on every state transition and whenever p disagrees with the candidate level.
- State machine:
  - IDLE: p=1 -> PRESS_WAIT. Otherwise stay.
  - PRESS_WAIT: p=0 -> IDLE, no output. Counter reaches DEBOUNCE_CYCLES-1 with p=1 -> PRESSED; set BTN_LEVEL=1; PRESS=1 for exactly one cycle.
  - PRESSED: p=0 -> RELEASE_WAIT.
  - RELEASE_WAIT: p=1 -> PRESSED, with no PRESS pulse and BTN_LEVEL unchanged. Counter reaches DEBOUNCE_CYCLES-1 with p=0 -> IDLE; BTN_LEVEL=0; RELEASE=1 for one cycle.
- Latency: BTN settles before CLK edge k -> PRESS (or RELEASE) is high in cycle k+2+DEBOUNCE_CYCLES, i.e. 2 synchroniser cycles plus the debounce window. BTN_LEVEL changes in that same cycle.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Pulse ordering: PRESS and RELEASE are never high together. At most one of them per transition.
- All outputs are registered; there are no combinational paths from BTN.
- Reset mid-operation (any state, mid-count): outputs drop to 0 immediately. After reset, a still-held button must be re-qualified through PRESS_WAIT and produces a fresh PRESS.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- With the macro:
  - A hold counter (width $clog2(LONG_CYCLES+1)) clears on entry to PRESSED from PRESS_WAIT.
  - It counts while in PRESSED or RELEASE_WAIT and saturates at LONG_CYCLES.
  - The cycle it reaches LONG_CYCLES-1, LONG_PRESS=1 for one cycle.
  - Fires at most once per accepted press. A release bounce that returns to PRESSED does not restart the count.
  - Hold counter clears in IDLE.
- Without the macro: the LONG_PRESS port and the hold counter are absent.

Decomposition:
- Shared package/include btn_pkg:
  - state encoding localparams: IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3
  - default timing constants for 100 MHz (10 ms, 1 s)
- One natural sub-module: sync_2ff, a two-flop synchroniser with async active-low reset and a reset-value parameter. It is reusable for other pin inputs.

Test Plan (sim with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BTN_ACTIVE_LOW=1):
- Reset with BTN=1 (released), 10 cycles -> BTN_LEVEL=0; PRESS, RELEASE and LONG_PRESS stay 0 throughout.
- BTN 1->0 clean, held -> PRESS high exactly in cycle k+6 for one cycle; BTN_LEVEL=1 from k+6.
- Press bounce: BTN toggles 0/1/0/1 each cycle for 8 cycles, then holds 0 -> no PRESS during bounce; exactly one PRESS 6 cycles after the final settle.
- Release with a 3-cycle bounce back to 0 in RELEASE_WAIT -> no RELEASE, no second PRESS; a clean release later gives one RELEASE 6 cycles after settle, BTN_LEVEL=0.
- BTN_LONG_PRESS_EN, hold 40 cycles -> LONG_PRESS exactly once, 20 cycles after PRESS; none on a second hold shorter than 20 cycles.
- RST_N asserted mid PRESS_WAIT and mid PRESSED with BTN held 0 -> outputs 0 asynchronously; after release of reset a new PRESS appears 6 cycles later.
